// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline hazard controller.
//   REG_AW      : register-file address width (5)
//   WAIT_W      : width of the memory-wait counter (covers timeouts up to 1023)
//   state_e     : controller FSM encoding (RUN=0, LOAD_STALL=1, MEM_WAIT=2,
//                 FLUSH=3); the encoding is visible on state_o
//   reg_addr_t  : register address type
//   addr_match  : non-zero address equality (x0 never produces a match)
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

  localparam int REG_AW = 5;
  localparam int WAIT_W = 10;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MEM_WAIT   = 2'd2,
    ST_FLUSH      = 2'd3
  } state_e;

  typedef logic [REG_AW-1:0] reg_addr_t;

  // x0 is hardwired to zero, so it can never be a real producer/consumer pair.
  function automatic logic addr_match(input reg_addr_t a, input reg_addr_t b);
    return (a != '0) && (a == b);
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_if
// Bundle between the pipeline datapath and the hazard controller.
//   Datapath -> controller : decode sources, execute destination, writeback
//                            destination, branch redirect, memory handshake
//   Controller -> datapath : stall / flush / bubble / hold, forwarding selects,
//                            sticky timeout flag, FSM state
// Modports:
//   slave  : the controller (pipe_ctrl)
//   master : the pipeline datapath
// -----------------------------------------------------------------------------
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;

  // decode stage
  reg_addr_t  id_rs1_addr;
  reg_addr_t  id_rs2_addr;
  logic       id_rs1_used;
  logic       id_rs2_used;
  // execute stage
  reg_addr_t  ex_rd_addr;
  logic       ex_wb_en;
  logic       ex_is_load;
  // writeback stage (EX/WB register outputs)
  reg_addr_t  wb_rd_addr;
  logic       wb_en;
  // redirect and memory handshake
  logic       br_mispredict;
  logic       mem_req;
  logic       mem_ready;
  // controls back to the pipeline
  logic       if_stall;
  logic       id_stall;
  logic       id_flush;
  logic       ex_bubble;
  logic       exwb_hold;
  logic       fwd_a;
  logic       fwd_b;
  logic       mem_timeout_err;
  logic [1:0] state_o;

  modport slave (
    input  id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
    input  ex_rd_addr, ex_wb_en, ex_is_load,
    input  wb_rd_addr, wb_en,
    input  br_mispredict, mem_req, mem_ready,
    output if_stall, id_stall, id_flush, ex_bubble, exwb_hold,
    output fwd_a, fwd_b, mem_timeout_err, state_o
  );

  modport master (
    output id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
    output ex_rd_addr, ex_wb_en, ex_is_load,
    output wb_rd_addr, wb_en,
    output br_mispredict, mem_req, mem_ready,
    input  if_stall, id_stall, id_flush, ex_bubble, exwb_hold,
    input  fwd_a, fwd_b, mem_timeout_err, state_o
  );

endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_hazard_detect
// Purely combinational register-address compare for the controller.
//   i_rs1_addr/i_rs2_addr, i_rs1_used/i_rs2_used : decode-stage sources
//   i_ex_rd_addr, i_ex_wb_en, i_ex_is_load        : execute-stage producer
//   i_wb_rd_addr, i_wb_en                         : writeback-stage producer
//   o_load_use : a load in EX writes a register a used source reads
//   o_fwd_a/b  : writeback result should replace regfile data for rs1/rs2
// -----------------------------------------------------------------------------
module pipe_ctrl_hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  reg_addr_t i_rs1_addr,
  input  reg_addr_t i_rs2_addr,
  input  logic      i_rs1_used,
  input  logic      i_rs2_used,
  input  reg_addr_t i_ex_rd_addr,
  input  logic      i_ex_wb_en,
  input  logic      i_ex_is_load,
  input  reg_addr_t i_wb_rd_addr,
  input  logic      i_wb_en,
  output logic      o_load_use,
  output logic      o_fwd_a,
  output logic      o_fwd_b
);

  reg_addr_t  w_rs_addr [2];
  logic       w_rs_used [2];
  logic [1:0] w_lu_hit;
  logic [1:0] w_fwd_hit;

  assign w_rs_addr[0] = i_rs1_addr;
  assign w_rs_addr[1] = i_rs2_addr;
  assign w_rs_used[0] = i_rs1_used;
  assign w_rs_used[1] = i_rs2_used;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      // Only sources the instruction actually reads can create a load-use stall.
      assign w_lu_hit[gi]  = w_rs_used[gi] & addr_match(i_ex_rd_addr, w_rs_addr[gi]);
      // Forwarding is not qualified by "used": selecting bypass data for an
      // unused operand is harmless.
      assign w_fwd_hit[gi] = i_wb_en & addr_match(i_wb_rd_addr, w_rs_addr[gi]);
    end
  endgenerate

  assign o_load_use = i_ex_is_load & i_ex_wb_en & (|w_lu_hit);
  assign o_fwd_a    = w_fwd_hit[0];
  assign o_fwd_b    = w_fwd_hit[1];

endmodule

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
// Hazard / stall controller for a short in-order pipeline: load-use stalls,
// branch-mispredict flushes, multi-cycle memory waits with a timeout, and
// writeback-to-decode forwarding selects.
//
// Parameters:
//   MEM_TIMEOUT : max stalled cycles for one memory wait before forced release
//                 (1..1023)
//   CNT_W       : width of the performance counters
// Ports:
//   clk   : rising-edge clock
//   rst   : synchronous, active-high reset
//   bus   : pipe_ctrl_if.slave (pipeline inputs, control outputs)
//   stall_cnt, flush_cnt : performance counters, present only when the macro
//                 PIPE_CTRL_PERF_EN is defined
//
// Control outputs are Mealy: an event seen in RUN is acted on in that same
// cycle, while the FSM remembers what follows.
// -----------------------------------------------------------------------------
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  pipe_ctrl_if.slave       bus
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam logic [WAIT_W-1:0] TIMEOUT_LIMIT = WAIT_W'(MEM_TIMEOUT);

  generate
    if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 1023 || CNT_W < 1) begin : g_param_check
      $error("pipe_ctrl: MEM_TIMEOUT must be 1..1023 and CNT_W at least 1");
    end
  endgenerate

  state_e            r_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_timeout_err;
  logic              r_br_pend;

  logic w_load_use;
  logic w_fwd_a;
  logic w_fwd_b;
  logic w_mispredict;
  logic w_mem_wait;
  logic w_timeout;
  logic w_if_stall;
  logic w_id_stall;
  logic w_id_flush;
  logic w_ex_bubble;
  logic w_exwb_hold;

  pipe_ctrl_hazard_detect hazard_detect (
    .i_rs1_addr   (bus.id_rs1_addr),
    .i_rs2_addr   (bus.id_rs2_addr),
    .i_rs1_used   (bus.id_rs1_used),
    .i_rs2_used   (bus.id_rs2_used),
    .i_ex_rd_addr (bus.ex_rd_addr),
    .i_ex_wb_en   (bus.ex_wb_en),
    .i_ex_is_load (bus.ex_is_load),
    .i_wb_rd_addr (bus.wb_rd_addr),
    .i_wb_en      (bus.wb_en),
    .o_load_use   (w_load_use),
    .o_fwd_a      (w_fwd_a),
    .o_fwd_b      (w_fwd_b)
  );

  // A redirect that arrived while the pipe was frozen is replayed on return
  // to RUN, since the branch itself may have moved on by then.
  assign w_mispredict = bus.br_mispredict | r_br_pend;
  assign w_mem_wait   = bus.mem_req & ~bus.mem_ready;
  // The entry cycle in RUN already counts as one waited cycle.
  assign w_timeout    = (r_wait_cnt >= TIMEOUT_LIMIT);

  always_comb begin
    w_if_stall  = 1'b0;
    w_id_stall  = 1'b0;
    w_id_flush  = 1'b0;
    w_ex_bubble = 1'b0;
    w_exwb_hold = 1'b0;
    if (!rst) begin
      unique case (r_state)
        ST_RUN: begin
          if (w_mispredict) begin
            w_id_flush  = 1'b1;
            w_ex_bubble = 1'b1;
          end else if (w_mem_wait) begin
            w_if_stall  = 1'b1;
            w_id_stall  = 1'b1;
            w_exwb_hold = 1'b1;
          end else if (w_load_use) begin
            w_if_stall  = 1'b1;
            w_id_stall  = 1'b1;
            w_ex_bubble = 1'b1;
          end
        end
        ST_MEM_WAIT: begin
          // Released combinationally on the mem_ready (or timeout) cycle.
          if (!bus.mem_ready && !w_timeout) begin
            w_if_stall  = 1'b1;
            w_id_stall  = 1'b1;
            w_exwb_hold = 1'b1;
          end
        end
        ST_FLUSH: begin
          // Second flush kills the wrong-path fetch that was already in IF.
          w_id_flush = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_RUN;
      r_wait_cnt    <= '0;
      r_timeout_err <= 1'b0;
      r_br_pend     <= 1'b0;
    end else begin
      unique case (r_state)
        ST_RUN: begin
          if (w_mispredict) begin
            r_state   <= ST_FLUSH;
            r_br_pend <= 1'b0;
          end else if (w_mem_wait) begin
            r_state    <= ST_MEM_WAIT;
            r_wait_cnt <= WAIT_W'(1);
          end else if (w_load_use) begin
            r_state <= ST_LOAD_STALL;
          end
        end
        ST_LOAD_STALL: begin
          r_br_pend <= r_br_pend | bus.br_mispredict;
          r_state   <= ST_RUN;
        end
        ST_MEM_WAIT: begin
          r_br_pend <= r_br_pend | bus.br_mispredict;
          if (bus.mem_ready) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
          end else if (w_timeout) begin
            r_state       <= ST_RUN;
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
          end
        end
        ST_FLUSH: begin
          // A redirect here belongs to the flushed wrong path: dropped.
          r_state <= ST_RUN;
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_if_stall) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (r_state == ST_RUN && w_mispredict) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

  assign bus.if_stall        = w_if_stall;
  assign bus.id_stall        = w_id_stall;
  assign bus.id_flush        = w_id_flush;
  assign bus.ex_bubble       = w_ex_bubble;
  assign bus.exwb_hold       = w_exwb_hold;
  assign bus.fwd_a           = w_fwd_a;
  assign bus.fwd_b           = w_fwd_b;
  assign bus.mem_timeout_err = r_timeout_err;
  assign bus.state_o         = r_state;

endmodule
